// File: rtl/store_commit_buffer_pkg.sv
// Shared types and sizing for the retired-store commit buffer.
// Entry format, index/count widths and drain FSM states live here.
package store_commit_buffer_pkg;

    localparam int WB_SZ        = 8;
    localparam int RETIRE_W     = 2;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int NUM_LANES    = DATA_W / 8;
    localparam int WB_IDX_BITS  = $clog2(WB_SZ);
    localparam int WB_CNT_BITS  = $clog2(WB_SZ + 1);
    localparam int RET_CNT_BITS = $clog2(RETIRE_W + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic [NUM_LANES-1:0] byte_mask;
    } store_commit_packet_t;

    typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WAIT} wb_state_e;

    // Forwarding granularity is the 4-byte word; low address bits are ignored.
    function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bundle of the SQ retire port, load-forwarding port and D-cache write port.
// slave = the buffer itself, master = its surroundings (SQ, LSU, D-cache).
interface store_commit_buffer_if;
    import store_commit_buffer_pkg::*;

    logic [RET_CNT_BITS-1:0]             retire_count;
    store_commit_packet_t [RETIRE_W-1:0] retire_stores;
    logic [RET_CNT_BITS-1:0]             wb_spots;
    logic                                wb_empty;
    logic [ADDR_W-1:0]                   ld_addr;
    logic                                ld_fwd_valid;
    logic [NUM_LANES-1:0]                ld_fwd_mask;
    logic [DATA_W-1:0]                   ld_fwd_data;
    logic                                dc_req_valid;
    logic [ADDR_W-1:0]                   dc_req_addr;
    logic [DATA_W-1:0]                   dc_req_data;
    logic [NUM_LANES-1:0]                dc_req_mask;
    logic                                dc_req_ready;
    logic                                dc_resp_done;

    modport slave (
        input  retire_count, retire_stores, ld_addr, dc_req_ready, dc_resp_done,
        output wb_spots, wb_empty, ld_fwd_valid, ld_fwd_mask, ld_fwd_data,
               dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask
    );

    modport master (
        output retire_count, retire_stores, ld_addr, dc_req_ready, dc_resp_done,
        input  wb_spots, wb_empty, ld_fwd_valid, ld_fwd_mask, ld_fwd_data,
               dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask
    );

endinterface

// File: rtl/store_commit_buffer_wb_fwd_select.sv
// Combinational load forwarding: per byte lane, the youngest valid entry whose
// word matches ld_addr and whose mask bit is set supplies the byte.
module wb_fwd_select
    import store_commit_buffer_pkg::*;
(
    input  store_commit_packet_t [WB_SZ-1:0] entries,
    input  logic [WB_IDX_BITS-1:0]           head,
    input  logic [WB_CNT_BITS-1:0]           count,
    input  logic [ADDR_W-1:0]                ld_addr,
    output logic [NUM_LANES-1:0]             fwd_mask,
    output logic [DATA_W-1:0]                fwd_data
);

    // Rotate into age order (slot 0 = head = oldest) so wrap-around needs no special case.
    store_commit_packet_t [WB_SZ-1:0] by_age;
    logic [WB_SZ-1:0]                 hit;

    always_comb begin
        by_age = '0;
        hit    = '0;
        for (int i = 0; i < WB_SZ; i++) begin
            by_age[i] = entries[WB_IDX_BITS'(int'(head) + i)];
            hit[i]    = (i < int'(count)) && word_match(by_age[i].addr, ld_addr);
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic       lane_hit;
        logic [7:0] lane_byte;

        // Later (younger) slots overwrite earlier ones.
        always_comb begin
            lane_hit  = 1'b0;
            lane_byte = '0;
            for (int i = 0; i < WB_SZ; i++) begin
                if (hit[i] && by_age[i].byte_mask[l]) begin
                    lane_hit  = 1'b1;
                    lane_byte = by_age[i].data[8*l +: 8];
                end
            end
        end

        assign fwd_mask[l]          = lane_hit;
        assign fwd_data[8*l +: 8]   = lane_byte;
    end

endmodule

// File: rtl/store_commit_buffer.sv
// Retired-store write buffer: FIFO of committed stores drained in order to the
// D-cache one write at a time, with byte-merged forwarding to loads.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
(
    input logic                  clock,
    input logic                  reset,
    store_commit_buffer_if.slave sif
);

    store_commit_packet_t [WB_SZ-1:0] entries_q, entries_d;
    logic [WB_IDX_BITS-1:0]           head_q, head_d, tail_q, tail_d;
    logic [WB_CNT_BITS-1:0]           count_q, count_d;
    wb_state_e                        state_q, state_d;
    logic                             pop;
    logic [WB_CNT_BITS-1:0]           free_cnt;

    always_comb begin
        entries_d = entries_q;
        state_d   = state_q;
        pop       = (state_q == WB_WAIT) && sif.dc_resp_done;

        for (int r = 0; r < RETIRE_W; r++) begin
            if (r < int'(sif.retire_count))
                entries_d[WB_IDX_BITS'(int'(tail_q) + r)] = sif.retire_stores[r];
        end
        tail_d  = tail_q + WB_IDX_BITS'(sif.retire_count);
        head_d  = head_q + WB_IDX_BITS'(pop);
        count_d = count_q + WB_CNT_BITS'(sif.retire_count) - WB_CNT_BITS'(pop);

        // Decisions use the registered count, so fresh entries wait one edge.
        unique case (state_q)
            WB_IDLE: if (count_q != '0) state_d = WB_REQ;
            WB_REQ:  if (sif.dc_req_ready) state_d = WB_WAIT;
            WB_WAIT: if (sif.dc_resp_done)
                         state_d = (count_q > WB_CNT_BITS'(1)) ? WB_REQ : WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= WB_IDLE;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    // A same-cycle pop is deliberately not credited, keeping wb_spots conservative.
    assign free_cnt     = WB_CNT_BITS'(WB_SZ) - count_q;
    assign sif.wb_spots = (free_cnt < WB_CNT_BITS'(RETIRE_W)) ? RET_CNT_BITS'(free_cnt)
                                                               : RET_CNT_BITS'(RETIRE_W);
    assign sif.wb_empty = (count_q == '0) && (state_q == WB_IDLE);

    // Head stays resident until done, so it is still visible to forwarding.
    assign sif.dc_req_valid = (state_q == WB_REQ);
    assign sif.dc_req_addr  = entries_q[head_q].addr;
    assign sif.dc_req_data  = entries_q[head_q].data;
    assign sif.dc_req_mask  = entries_q[head_q].byte_mask;

    wb_fwd_select u_fwd (
        .entries  (entries_q),
        .head     (head_q),
        .count    (count_q),
        .ld_addr  (sif.ld_addr),
        .fwd_mask (sif.ld_fwd_mask),
        .fwd_data (sif.ld_fwd_data)
    );

    assign sif.ld_fwd_valid = |sif.ld_fwd_mask;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized + directed bench for store_commit_buffer against a queue-based
// model of the buffer contents, drain protocol and byte-merged forwarding.
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_commit_buffer_if sif();

    store_commit_buffer dut (
        .clock (clk),
        .reset (rst_n),
        .sif   (sif)
    );

    // Model: queue of buffered stores, oldest first; drain phase 0=idle 1=req 2=wait.
    store_commit_packet_t mq[$];
    int ph;
    int dc_cnt;
    int dc_lat = 3;
    int n_chk  = 0;
    int n_err  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic store_commit_packet_t pk(input logic [31:0] a, input logic [31:0] d,
                                                input logic [3:0] m);
        store_commit_packet_t p;
        p.addr = a; p.data = d; p.byte_mask = m;
        return p;
    endfunction

    function automatic int spots_exp();
        int free;
        free = WB_SZ - mq.size();
        return (free < RETIRE_W) ? free : RETIRE_W;
    endfunction

    task automatic check_state();
        chk("wb_spots", sif.wb_spots, spots_exp());
        chk("wb_empty", sif.wb_empty, mq.size() == 0 && ph == 0);
        chk("dc_req_valid", sif.dc_req_valid, ph == 1);
        if (ph == 1) begin
            chk("dc_req_addr", sif.dc_req_addr, mq[0].addr);
            chk("dc_req_data", sif.dc_req_data, mq[0].data);
            chk("dc_req_mask", sif.dc_req_mask, mq[0].byte_mask);
        end
    endtask

    task automatic check_fwd();
        logic [3:0]  m;
        logic [31:0] d;
        m = '0; d = '0;
        foreach (mq[i])
            if (mq[i].addr[31:2] == sif.ld_addr[31:2])
                for (int b = 0; b < 4; b++)
                    if (mq[i].byte_mask[b]) begin
                        m[b] = 1'b1;
                        d[8*b +: 8] = mq[i].data[8*b +: 8];
                    end
        chk("ld_fwd_valid", sif.ld_fwd_valid, |m);
        chk("ld_fwd_mask", sif.ld_fwd_mask, m);
        chk("ld_fwd_data", sif.ld_fwd_data, d);
    endtask

    // Called at posedge+1: drive one cycle of inputs, check forwarding, advance model.
    task automatic step(input int rc, input store_commit_packet_t s0, input store_commit_packet_t s1,
                        input logic [31:0] ld, input logic rdy, input logic spur);
        logic done;
        logic pop;
        done = (ph == 2 && dc_cnt == 0) || spur;
        sif.retire_count     = RET_CNT_BITS'(rc);
        sif.retire_stores[0] = s0;
        sif.retire_stores[1] = s1;
        sif.ld_addr          = ld;
        sif.dc_req_ready     = rdy;
        sif.dc_resp_done     = done;
        #1;
        check_fwd();
        @(posedge clk);
        #1;
        pop = (ph == 2) && done;
        case (ph)
            0: if (mq.size() > 0) ph = 1;
            1: if (rdy) begin ph = 2; dc_cnt = dc_lat - 1; end
            default: if (done) ph = (mq.size() > 1) ? 1 : 0;
                     else if (dc_cnt > 0) dc_cnt--;
        endcase
        if (pop) void'(mq.pop_front());
        if (rc > 0) mq.push_back(s0);
        if (rc > 1) mq.push_back(s1);
        check_state();
    endtask

    function automatic store_commit_packet_t rnd_pk();
        return pk(32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)));
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_spots"}, sif.wb_spots, RETIRE_W);
        chk({tag, "_empty"}, sif.wb_empty, 1);
        chk({tag, "_req_valid"}, sif.dc_req_valid, 0);
        chk({tag, "_fwd_valid"}, sif.ld_fwd_valid, 0);
        chk({tag, "_fwd_mask"}, sif.ld_fwd_mask, 0);
        chk({tag, "_fwd_data"}, sif.ld_fwd_data, 0);
    endtask

    task automatic idle_inputs();
        sif.retire_count  = '0;
        sif.retire_stores = '0;
        sif.dc_req_ready  = 1'b0;
        sif.dc_resp_done  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        store_commit_packet_t z;
        bit hit_simul;
        int rc;
        z = '0;
        mq.delete(); ph = 0; dc_cnt = 0;

        // Reset values without any clock edge
        idle_inputs();
        sif.ld_addr = 32'h100;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst0");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state();

        // Drain order with done three cycles after accept
        dc_lat = 3;
        step(2, pk(32'h100, 32'hAABBCCDD, 4'hF), pk(32'h104, 32'h01020304, 4'hF), 32'h104, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(0, z, z, 32'h104, 1'b1, 1'b0);
        chk("drain_empty", sif.wb_empty, 1);

        // Byte-merge forwarding from two stores to the same word
        step(1, pk(32'h200, 32'h11223344, 4'hF), z, 32'h200, 1'b0, 1'b0);
        step(1, pk(32'h200, 32'h0000AABB, 4'h3), z, 32'h200, 1'b0, 1'b0);
        sif.ld_addr = 32'h202; #1;
        chk("merge_valid", sif.ld_fwd_valid, 1);
        chk("merge_mask", sif.ld_fwd_mask, 4'hF);
        chk("merge_data", sif.ld_fwd_data, 32'h1122AABB);
        sif.ld_addr = 32'h204; #1;
        chk("miss_valid", sif.ld_fwd_valid, 0);
        chk("miss_mask", sif.ld_fwd_mask, 0);
        chk("miss_data", sif.ld_fwd_data, 0);
        for (int i = 0; i < 30 && (mq.size() > 0 || ph != 0); i++) step(0, z, z, 32'h200, 1'b1, 1'b0);
        chk("merge_drain_left", mq.size(), 0);

        // Fill to full under backpressure, then simultaneous retire + pop at count 6
        for (int i = 0; i < 4; i++) step(2, rnd_pk(), rnd_pk(), 32'h304, 1'b0, 1'b0);
        chk("full_spots", sif.wb_spots, 0);
        dc_lat = 2;
        hit_simul = 1'b0;
        for (int i = 0; i < 40 && !hit_simul; i++) begin
            if (ph == 2 && dc_cnt == 0 && mq.size() == 6) begin
                step(2, rnd_pk(), rnd_pk(), 32'h308, 1'b1, 1'b0);
                chk("simul_spots", sif.wb_spots, 1);
                hit_simul = 1'b1;
            end else begin
                step(0, z, z, 32'h308, 1'b1, 1'b0);
            end
        end
        chk("simul_reached", hit_simul, 1);

        // Random traffic, wrapping the ring many times
        for (int i = 0; i < 400; i++) begin
            dc_lat = $urandom_range(1, 4);
            rc = $urandom_range(0, spots_exp());
            step(rc, rnd_pk(), rnd_pk(),
                 ($urandom_range(0, 7) == 0) ? 32'h400 : 32'h300 + 32'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, ph != 2 && $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 100 && (mq.size() > 0 || ph != 0); i++) step(0, z, z, 32'h300, 1'b1, 1'b0);
        chk("final_drain_left", mq.size(), 0);

        // Mid-cycle reset with a write in flight; a late done must be ignored
        dc_lat = 20;
        step(2, pk(32'h500, 32'hCAFEF00D, 4'hF), pk(32'h504, 32'h12345678, 4'hF), 32'h500, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(0, z, z, 32'h500, 1'b1, 1'b0);
        chk("pre_rst_fwd", sif.ld_fwd_valid, 1);
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        @(posedge clk);
        #3 rst_n = 1'b1;
        mq.delete(); ph = 0; dc_cnt = 0;
        @(posedge clk); #1;
        step(0, z, z, 32'h500, 1'b1, 1'b1);
        chk("late_done_empty", sif.wb_empty, 1);
        step(0, z, z, 32'h500, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
